// File: rtl/counter_strobe_modal.sv
// Modal tick counter: strobes once per period_active accepted ticks, periodic or one-shot.
// Latency: strobe/valid/count one cycle after an accepted tick; ready drops for LATENCY idle cycles after any enable.
module counter_strobe_modal #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] reset_value,
  input  logic             load,
  input  logic             one_shot,
  input  logic             arm,
  output logic             strobe,
  output logic             ready,
  output logic             valid,
  output logic             armed,
  output logic [WIDTH-1:0] count,
  output logic             missed
);

  localparam int RDY_W = LATENCY + 1;

  logic [WIDTH-1:0] period_active;
  logic [WIDTH-1:0] period_shadow;
  logic             pending;
  logic [RDY_W-1:0] rdy_sr;
  logic [RDY_W-1:0] rdy_shift;

  logic             tick;
  logic             trigger;
  logic             fire;

  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] period_active_nxt;
  logic [WIDTH-1:0] period_shadow_nxt;
  logic             pending_nxt;
  logic             armed_nxt;
  logic             missed_nxt;
  logic [RDY_W-1:0] rdy_nxt;

  // With no spacing required the tracker is a single bit that never leaves 1.
  generate
    if (LATENCY == 0) begin : g_no_spacing
      assign rdy_shift = 1'b1;
    end else begin : g_spacing
      assign rdy_shift = {rdy_sr[LATENCY-1:0], 1'b1};
    end
  endgenerate

  assign ready   = rdy_sr[LATENCY];
  assign tick    = enable & ready & armed;
  assign trigger = (count >= period_active);
  assign fire    = tick & trigger;

  always_comb begin
    count_nxt         = count;
    period_active_nxt = period_active;
    period_shadow_nxt = period_shadow;
    pending_nxt       = pending;
    armed_nxt         = armed;
    missed_nxt        = missed | (enable & ~ready & armed);
    rdy_nxt           = enable ? RDY_W'(1) : rdy_shift;

    if (tick) begin
      count_nxt = trigger ? WIDTH'(1) : count + WIDTH'(1);
    end

    if (load) begin
      period_shadow_nxt = reset_value;
      pending_nxt       = 1'b1;
    end

    // A load landing on the trigger itself bypasses the shadow register.
    if (fire) begin
      if (load) begin
        period_active_nxt = reset_value;
        pending_nxt       = 1'b0;
      end else if (pending) begin
        period_active_nxt = period_shadow;
        pending_nxt       = 1'b0;
      end
    end

    if (fire && one_shot) begin
      armed_nxt = 1'b0;
    end
    if (arm) begin
      armed_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= WIDTH'(1);
      strobe        <= 1'b0;
      valid         <= 1'b0;
      missed        <= 1'b0;
      armed         <= 1'b1;
      pending       <= 1'b0;
      rdy_sr        <= RDY_W'(1);
      period_active <= reset_value;
      period_shadow <= reset_value;
    end else begin
      count         <= count_nxt;
      strobe        <= fire;
      valid         <= tick;
      missed        <= missed_nxt;
      armed         <= armed_nxt;
      pending       <= pending_nxt;
      rdy_sr        <= rdy_nxt;
      period_active <= period_active_nxt;
      period_shadow <= period_shadow_nxt;
    end
  end

endmodule

// File: tb/tb_counter_strobe_modal.sv
// Directed scenarios on two instances (LATENCY=1 and LATENCY=2); expected tick results are queued
// at issue time and popped by per-instance monitors whenever valid is high.
module tb_counter_strobe_modal;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst1, rst2, en1, en2, load, one_shot, arm;
  logic [W-1:0] rv;
  logic         s1, r1, v1, a1, m1;
  logic         s2, r2, v2, a2, m2;
  logic [W-1:0] c1, c2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic         s;
    logic [W-1:0] c;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  counter_strobe_modal #(.WIDTH(W), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst1), .enable(en1), .reset_value(rv), .load(load),
    .one_shot(one_shot), .arm(arm), .strobe(s1), .ready(r1), .valid(v1),
    .armed(a1), .count(c1), .missed(m1)
  );

  counter_strobe_modal #(.WIDTH(W), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst2), .enable(en2), .reset_value(rv), .load(load),
    .one_shot(one_shot), .arm(arm), .strobe(s2), .ready(r2), .valid(v2),
    .armed(a2), .count(c2), .missed(m2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One accepted tick on dut1 followed by the single idle cycle LATENCY=1 needs.
  task automatic tick1(input logic ld, input logic [W-1:0] v, input logic am,
                       input logic es, input logic [W-1:0] ec);
    exp_t e;
    e.s = es;
    e.c = ec;
    q1.push_back(e);
    en1  = 1'b1;
    load = ld;
    if (ld) rv = v;
    arm  = am;
    cyc();
    en1  = 1'b0;
    load = 1'b0;
    arm  = 1'b0;
    cyc();
  endtask

  task automatic reset1(input logic [W-1:0] v, input logic os);
    rst1     = 1'b1;
    rv       = v;
    one_shot = os;
    en1      = 1'b0;
    cyc();
    cyc();
    rst1 = 1'b0;
  endtask

  // Scoreboard monitors plus the continuous strobe rules.
  logic ps1 = 1'b0;
  logic ps2 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (v1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1 unexpected valid: strobe=%0b count=%0d", s1, c1);
      end else begin
        e = q1.pop_front();
        chk("dut1 strobe", int'(s1), int'(e.s));
        chk("dut1 count", int'(c1), int'(e.c));
      end
    end
    chk("dut1 strobe without valid", int'(s1 & ~v1), 0);
    chk("dut1 strobe two cycles", int'(s1 & ps1), 0);
    ps1 = s1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (v2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut2 unexpected valid: strobe=%0b count=%0d", s2, c2);
      end else begin
        e = q2.pop_front();
        chk("dut2 strobe", int'(s2), int'(e.s));
        chk("dut2 count", int'(c2), int'(e.c));
      end
    end
    chk("dut2 strobe without valid", int'(s2 & ~v2), 0);
    chk("dut2 strobe two cycles", int'(s2 & ps2), 0);
    ps2 = s2;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] pc [9] = '{8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd1};
    logic         ps [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] lc [7] = '{8'd3, 8'd4, 8'd1, 8'd2, 8'd1, 8'd2, 8'd1};
    logic         ls [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_t         e;

    rst1 = 1'b1; rst2 = 1'b1; en1 = 1'b0; en2 = 1'b0;
    load = 1'b0; one_shot = 1'b0; arm = 1'b0; rv = 8'd3;

    // Periodic, period 3: strobes on ticks 3, 6, 9.
    reset1(8'd3, 1'b0);
    chk("reset count", int'(c1), 1);
    chk("reset strobe", int'(s1), 0);
    chk("reset valid", int'(v1), 0);
    chk("reset missed", int'(m1), 0);
    chk("reset armed", int'(a1), 1);
    chk("reset ready", int'(r1), 0);
    cyc();
    chk("ready after 1 idle", int'(r1), 1);
    for (int i = 0; i < 9; i++) tick1(1'b0, '0, 1'b0, ps[i], pc[i]);
    chk("periodic end count", int'(c1), 1);
    chk("periodic missed", int'(m1), 0);

    // Shadow load: period 4, load 2 after tick 1; strobes at 4, 6, 8.
    reset1(8'd4, 1'b0);
    cyc();
    tick1(1'b0, '0, 1'b0, 1'b0, 8'd2);
    load = 1'b1; rv = 8'd2;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 7; i++) tick1(1'b0, '0, 1'b0, ls[i], lc[i]);

    // Coincident load at the trigger: next strobe five ticks later.
    tick1(1'b0, '0, 1'b0, 1'b0, 8'd2);
    tick1(1'b1, 8'd5, 1'b0, 1'b1, 8'd1);
    for (int i = 2; i <= 5; i++) tick1(1'b0, '0, 1'b0, 1'b0, W'(i));
    tick1(1'b0, '0, 1'b0, 1'b1, 8'd1);

    // One-shot, period 2.
    reset1(8'd2, 1'b1);
    cyc();
    tick1(1'b0, '0, 1'b0, 1'b0, 8'd2);
    tick1(1'b0, '0, 1'b0, 1'b1, 8'd1);
    chk("oneshot disarmed", int'(a1), 0);
    en1 = 1'b1;
    cyc();
    cyc();
    en1 = 1'b0;
    cyc();
    chk("disarmed armed", int'(a1), 0);
    chk("disarmed count", int'(c1), 1);
    chk("disarmed enable not missed", int'(m1), 0);
    arm = 1'b1;
    cyc();
    arm = 1'b0;
    chk("rearmed", int'(a1), 1);
    tick1(1'b0, '0, 1'b0, 1'b0, 8'd2);
    tick1(1'b0, '0, 1'b1, 1'b1, 8'd1);
    chk("arm wins over trigger", int'(a1), 1);
    tick1(1'b0, '0, 1'b0, 1'b0, 8'd2);
    tick1(1'b0, '0, 1'b0, 1'b1, 8'd1);
    chk("oneshot disarmed again", int'(a1), 0);

    // Handshake on the LATENCY=2 instance.
    one_shot = 1'b0;
    rv = 8'd5;
    cyc();
    cyc();
    rst2 = 1'b0;
    cyc();
    chk("lat2 ready after 1 idle", int'(r2), 0);
    chk("lat2 armed", int'(a2), 1);
    cyc();
    chk("lat2 ready after 2 idle", int'(r2), 1);
    e.s = 1'b0;
    e.c = 8'd2;
    q2.push_back(e);
    en2 = 1'b1;
    cyc();
    cyc();
    en2 = 1'b0;
    cyc();
    chk("lat2 missed", int'(m2), 1);
    chk("lat2 count", int'(c2), 2);
    rst2 = 1'b1;
    cyc();
    chk("lat2 missed cleared", int'(m2), 0);

    // Reset mid-count with enable, load and arm all asserted.
    reset1(8'd5, 1'b0);
    cyc();
    tick1(1'b0, '0, 1'b0, 1'b0, 8'd2);
    tick1(1'b0, '0, 1'b0, 1'b0, 8'd3);
    load = 1'b1; rv = 8'd2;
    cyc();
    rst1 = 1'b1; en1 = 1'b1; load = 1'b1; arm = 1'b1; rv = 8'd5;
    cyc();
    chk("midreset count", int'(c1), 1);
    chk("midreset valid", int'(v1), 0);
    chk("midreset strobe", int'(s1), 0);
    chk("midreset ready", int'(r1), 0);
    rst1 = 1'b0; en1 = 1'b0; load = 1'b0; arm = 1'b0;
    cyc();
    chk("post reset ready", int'(r1), 1);
    chk("post reset count", int'(c1), 1);
    for (int i = 2; i <= 5; i++) tick1(1'b0, '0, 1'b0, 1'b0, W'(i));
    tick1(1'b0, '0, 1'b0, 1'b1, 8'd1);

    cyc();
    chk("dut1 queue drained", q1.size(), 0);
    chk("dut2 queue drained", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
